pixel_array_sequencer: RTL and testbench

Digital timing and readout sequencer for a parametrised N_ROWS × N_COLS pixel sensor array. It drives the shared erase, expose and ramp controls and the one-hot row-read strobes, and it drives the ADC count onto the column buses during conversion. It captures one row of latched pixel codes at a time and streams them out over a valid/ready interface. It sits between the frame-level control logic and the analog pixel array, replacing hand-driven ERASE/EXPOSE/READn stimulus.

---
 rtl/pixel_seq_pkg.sv | 27 ++
 rtl/pixel_row_serializer.sv | 57 +++++
 rtl/pixel_array_sequencer.sv | 136 +++++++++++++
 tb/tb_pixel_array_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_seq_pkg.sv
// Shared types for the pixel array sequencer: FSM state encoding and a
// helper giving the nominal start-to-frame_done cycle count.
package pixel_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    READ_SEL,
    READ_CAP,
    EMIT,
    DONE
  } state_t;

  // Cycles from the IDLE cycle that samples start to the DONE cycle, with px_ready held high.
  function automatic int unsigned frame_len(input int unsigned n_rows,
                                            input int unsigned n_cols,
                                            input int unsigned adc_bits,
                                            input int unsigned erase_cycles,
                                            input int unsigned expose);
    int unsigned exp_eff;
    exp_eff = (expose == 0) ? 1 : expose;
    return 1 + erase_cycles + exp_eff + (32'd1 << adc_bits) + n_rows * (2 + n_cols);
  endfunction

endpackage

// File: rtl/pixel_row_serializer.sv
// Row buffer loaded in parallel from the column buses, streamed out one
// column per accepted valid/ready beat.
module pixel_row_serializer #(
  parameter int N_COLS   = 2,
  parameter int ADC_BITS = 8,
  parameter int ROW_W    = 1,
  parameter int COL_W    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [ROW_W-1:0]           row_in,
  input  logic [N_COLS*ADC_BITS-1:0] col_data,
  input  logic                       px_ready,
  output logic                       px_valid,
  output logic [ADC_BITS-1:0]        px_data,
  output logic [ROW_W-1:0]           px_row,
  output logic [COL_W-1:0]           px_col,
  output logic                       last_beat
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS - 1);

  logic [ADC_BITS-1:0] buffer [N_COLS];
  logic                valid_q;
  logic [COL_W-1:0]    col_q;
  logic [ROW_W-1:0]    row_q;
  logic                accept;

  assign accept    = valid_q && px_ready;
  assign last_beat = accept && (col_q == LAST_COL);

  // NOTE: the row buffer is reset along with the control flops so an aborted frame leaves no stale codes behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      for (int c = 0; c < N_COLS; c++) buffer[c] <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      col_q   <= '0;
      row_q   <= row_in;
      for (int c = 0; c < N_COLS; c++) buffer[c] <= col_data[c*ADC_BITS +: ADC_BITS];
    end else if (accept) begin
      if (col_q == LAST_COL) valid_q <= 1'b0;
      else                   col_q   <= col_q + COL_W'(1);
    end
  end

  // Gated so the stream outputs read zero whenever no beat is offered.
  assign px_valid = valid_q;
  assign px_data  = valid_q ? buffer[col_q] : '0;
  assign px_row   = valid_q ? row_q : '0;
  assign px_col   = valid_q ? col_q : '0;

endmodule

// File: rtl/pixel_array_sequencer.sv
// Frame sequencer for the pixel array: erase/expose/convert timing, row
// selection and hand-off of each captured row to the pixel serializer.
module pixel_array_sequencer
  import pixel_seq_pkg::*;
#(
  parameter int N_ROWS       = 2,
  parameter int N_COLS       = 2,
  parameter int ADC_BITS     = 8,
  parameter int ERASE_CYCLES = 5,
  parameter int EXP_W        = 16,
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
  localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       continuous,
  input  logic [EXP_W-1:0]           expose_cycles,
  output logic                       pix_erase,
  output logic                       pix_expose,
  output logic                       ramp_en,
  output logic                       bus_drive,
  output logic [ADC_BITS-1:0]        adc_count,
  output logic [N_ROWS-1:0]          pix_read,
  input  logic [N_COLS*ADC_BITS-1:0] col_data,
  output logic                       px_valid,
  input  logic                       px_ready,
  output logic [ADC_BITS-1:0]        px_data,
  output logic [ROW_W-1:0]           px_row,
  output logic [COL_W-1:0]           px_col,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int PH_W = ((EXP_W > ADC_BITS) ? EXP_W : ADC_BITS) + 1;
  localparam logic [PH_W-1:0]  ERASE_LAST = PH_W'(ERASE_CYCLES - 1);
  localparam logic [PH_W-1:0]  CONV_LAST  = PH_W'((1 << ADC_BITS) - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(N_ROWS - 1);

  state_t           state, state_next;
  logic [PH_W-1:0]  phase;
  logic [EXP_W-1:0] exp_len;
  logic [ROW_W-1:0] row;
  logic             start_block;
  logic             phase_last;
  logic             launch;
  logic             resample;
  logic             last_beat;

  // A start still held from the previous frame must be released before it can launch another.
  assign launch   = (state == IDLE) && start && !start_block;
  assign resample = launch || ((state == DONE) && continuous);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    phase_last = 1'b0;
    case (state)
      ERASE:   phase_last = (phase == ERASE_LAST);
      EXPOSE:  phase_last = (phase == PH_W'(exp_len) - PH_W'(1));
      CONVERT: phase_last = (phase == CONV_LAST);
      default: phase_last = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (launch) state_next = ERASE;
      ERASE:    if (phase_last) state_next = EXPOSE;
      EXPOSE:   if (phase_last) state_next = CONVERT;
      CONVERT:  if (phase_last) state_next = READ_SEL;
      READ_SEL: state_next = READ_CAP;
      READ_CAP: state_next = EMIT;
      EMIT:     if (last_beat) state_next = (row == LAST_ROW) ? DONE : READ_SEL;
      DONE:     state_next = continuous ? ERASE : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    pix_erase  = (state == ERASE);
    pix_expose = (state == EXPOSE);
    ramp_en    = (state == CONVERT);
    bus_drive  = (state == CONVERT);
    adc_count  = (state == CONVERT) ? phase[ADC_BITS-1:0] : '0;
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    pix_read   = '0;
    if (state == READ_SEL || state == READ_CAP) pix_read = N_ROWS'(1) << row;
  end

  // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= '0;
      exp_len     <= '0;
      row         <= '0;
      start_block <= 1'b0;
    end else begin
      state <= state_next;

      // One counter times ERASE, EXPOSE and CONVERT; it restarts on every phase change.
      if (state_next != state || !(state inside {ERASE, EXPOSE, CONVERT})) phase <= '0;
      else                                                                 phase <= phase + PH_W'(1);

      if (resample) exp_len <= (expose_cycles == '0) ? EXP_W'(1) : expose_cycles;

      if (state == CONVERT)                                         row <= '0;
      else if (state == EMIT && last_beat && row != LAST_ROW) row <= row + ROW_W'(1);

      if (state == DONE) start_block <= start && !continuous;
      else if (!start)   start_block <= 1'b0;
    end
  end

  pixel_row_serializer #(
    .N_COLS  (N_COLS),
    .ADC_BITS(ADC_BITS),
    .ROW_W   (ROW_W),
    .COL_W   (COL_W)
  ) u_serializer (
    .clk      (clk),
    .reset    (reset),
    .load     (state == READ_CAP),
    .row_in   (row),
    .col_data (col_data),
    .px_ready (px_ready),
    .px_valid (px_valid),
    .px_data  (px_data),
    .px_row   (px_row),
    .px_col   (px_col),
    .last_beat(last_beat)
  );

endmodule

// File: tb/tb_pixel_array_sequencer.sv
// Scoreboard bench for pixel_array_sequencer: expected beats are queued when a
// frame is launched and popped as the DUT transfers them.
module tb_pixel_array_sequencer;

  localparam int ROW_W = 1;
  localparam int COL_W = 1;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [7:0]       data;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        continuous;
  logic [15:0] expose_cycles;
  logic        pix_erase, pix_expose, ramp_en, bus_drive;
  logic [7:0]  adc_count;
  logic [1:0]  pix_read;
  logic [15:0] col_data;
  logic        px_valid, px_ready;
  logic [7:0]  px_data;
  logic [ROW_W-1:0] px_row;
  logic [COL_W-1:0] px_col;
  logic        busy, frame_done;

  int vectors = 0;
  int miscompares = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  pixel_array_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .continuous   (continuous),
    .expose_cycles(expose_cycles),
    .pix_erase    (pix_erase),
    .pix_expose   (pix_expose),
    .ramp_en      (ramp_en),
    .bus_drive    (bus_drive),
    .adc_count    (adc_count),
    .pix_read     (pix_read),
    .col_data     (col_data),
    .px_valid     (px_valid),
    .px_ready     (px_ready),
    .px_data      (px_data),
    .px_row       (px_row),
    .px_col       (px_col),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  // Pixel array model: each row presents its codes only while its read strobe is high.
  always_comb begin
    col_data = 16'hA5A5;
    if (pix_read[0])      col_data = {8'h22, 8'h11};
    else if (pix_read[1]) col_data = {8'h44, 8'h33};
  end

  function automatic logic [42:0] all_outputs();
    return {pix_erase, pix_expose, ramp_en, bus_drive, adc_count, pix_read,
            px_valid, px_data, px_row, px_col, busy, frame_done, 16'h0};
  endfunction

  task automatic run_frame(input int exp_cyc, input int stall_len, input bit do_start,
                           input bit hold_start, input bit mid_start, input bit cont_next,
                           input bit abort_on_valid);
    int cnt, erase_n, expose_n, conv_n, beat_idx, stall_left, exp_lat, exp_eff;
    logic [7:0] adc_exp;
    beat_t b;
    bit done;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        b.row  = r[ROW_W-1:0];
        b.col  = c[COL_W-1:0];
        b.data = 8'(8'h11 * (r * 2 + c + 1));
        sb.push_back(b);
      end
    exp_eff = (exp_cyc == 0) ? 1 : exp_cyc;
    exp_lat = 1 + 5 + exp_eff + 256 + 8 + stall_len;
    expose_cycles = 16'(exp_cyc);
    if (do_start) start = 1'b1;
    cnt = 0; erase_n = 0; expose_n = 0; conv_n = 0; beat_idx = 0;
    stall_left = stall_len; adc_exp = 8'h00; done = 1'b0;
    px_ready = 1'b1;
    while (!done) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      start = hold_start || (mid_start && cnt == 50);
      if (cnt == 1) begin
        continuous = cont_next;
        vectors++;
        if ({pix_erase, busy} !== 2'b11) begin
          miscompares++;
          $display("FAIL erase_first_cycle: got erase/busy=%b expected 11", {pix_erase, busy});
        end
      end
      erase_n  += int'(pix_erase);
      expose_n += int'(pix_expose);
      if (bus_drive) begin
        conv_n++;
        vectors++;
        if (adc_count !== adc_exp || ramp_en !== 1'b1 || pix_read !== 2'b00) begin
          miscompares++;
          $display("FAIL convert: got adc=%0d ramp=%b read=%b expected adc=%0d ramp=1 read=00",
                   adc_count, ramp_en, pix_read, adc_exp);
        end
        adc_exp++;
      end
      if ($countones(pix_read) > 1) begin
        vectors++;
        miscompares++;
        $display("FAIL read_onehot: got pix_read=%b expected one-hot or zero", pix_read);
      end
      if (px_valid) begin
        if (abort_on_valid) begin
          reset = 1'b1;
          #1;
          vectors++;
          if (all_outputs() !== '0) begin
            miscompares++;
            $display("FAIL reset_abort: got outputs=%h expected 0", all_outputs());
          end
          sb.delete();
          return;
        end
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL extra_beat: got data=%h expected no beat", px_data);
          px_ready = 1'b1;
        end else if (beat_idx == 1 && stall_left > 0) begin
          px_ready = 1'b0;
          stall_left--;
          if (px_data !== sb[0].data || px_row !== sb[0].row || px_col !== sb[0].col) begin
            miscompares++;
            $display("FAIL stall_hold: got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                     px_row, px_col, px_data, sb[0].row, sb[0].col, sb[0].data);
          end
        end else begin
          px_ready = 1'b1;
          b = sb.pop_front();
          beat_idx++;
          if (px_data !== b.data || px_row !== b.row || px_col !== b.col) begin
            miscompares++;
            $display("FAIL beat%0d: got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                     beat_idx - 1, px_row, px_col, px_data, b.row, b.col, b.data);
          end
        end
      end else begin
        px_ready = 1'b1;
      end
      if (frame_done) begin
        done = 1'b1;
        vectors++;
        if (cnt !== exp_lat || erase_n !== 5 || expose_n !== exp_eff || conv_n !== 256 ||
            sb.size() !== 0) begin
          miscompares++;
          $display("FAIL frame: got lat=%0d erase=%0d expose=%0d conv=%0d left=%0d expected %0d/5/%0d/256/0",
                   cnt, erase_n, expose_n, conv_n, sb.size(), exp_lat, exp_eff);
        end
      end
      if (cnt > 2000) begin
        done = 1'b1;
        vectors++;
        miscompares++;
        $display("FAIL frame_timeout: got no frame_done after %0d cycles expected %0d", cnt, exp_lat);
        sb.delete();
      end
    end
  endtask

  task automatic idle_gap();
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || all_outputs() !== '0) begin
      miscompares++;
      $display("FAIL idle_after_frame: got busy=%b outputs=%h expected 0", busy, all_outputs());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; continuous = 1'b0; expose_cycles = 16'd10; px_ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (all_outputs() !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got outputs=%h expected 0", all_outputs());
    end
    reset = 1'b0;
    idle_gap();
  endtask

  task automatic test_default();
    run_frame(10, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_gap();
  endtask

  task automatic test_backpressure();
    run_frame(10, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_gap();
  endtask

  task automatic test_zero_expose();
    run_frame(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_gap();
  endtask

  task automatic test_continuous();
    continuous = 1'b1;
    run_frame(10, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    run_frame(3, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_gap();
  endtask

  task automatic test_held_start();
    run_frame(10, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) idle_gap();
    start = 1'b0;
    idle_gap();
  endtask

  task automatic test_reset_mid_frame();
    run_frame(10, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    idle_gap();
    run_frame(10, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_gap();
  endtask

  initial begin
    test_reset();
    test_default();
    test_backpressure();
    test_zero_expose();
    test_continuous();
    test_held_start();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
